// File: rtl/hazard_if.sv
// Hazard controller bus bundle.
// Groups the pipeline-side signals the hazard controller observes and the
// pipeline control signals it drives.
//   ID stage   : id_ra, id_rb, id_rd_src, id_use_a/b/d
//   EXE stage  : ex_rd, ex_rf_en, ex_load, ex_branch_taken
//   MEM stage  : mem_rd, mem_rf_en, mem_req, mem_ready
//   WB stage   : wb_rd, wb_rf_en
//   Controls   : pc_ifid_le, ifid_flush, idex_nop, pipe_freeze, fwd_a/b/d
// modport slave  : the hazard controller view (stage info in, controls out)
// modport master : the pipeline view (stage info out, controls in)
interface hazard_if;
    logic [3:0] id_ra;
    logic [3:0] id_rb;
    logic [3:0] id_rd_src;
    logic       id_use_a;
    logic       id_use_b;
    logic       id_use_d;
    logic [3:0] ex_rd;
    logic       ex_rf_en;
    logic       ex_load;
    logic       ex_branch_taken;
    logic [3:0] mem_rd;
    logic       mem_rf_en;
    logic       mem_req;
    logic       mem_ready;
    logic [3:0] wb_rd;
    logic       wb_rf_en;
    logic       pc_ifid_le;
    logic       ifid_flush;
    logic       idex_nop;
    logic       pipe_freeze;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic [1:0] fwd_d;

    modport slave (
        input  id_ra, id_rb, id_rd_src, id_use_a, id_use_b, id_use_d,
        input  ex_rd, ex_rf_en, ex_load, ex_branch_taken,
        input  mem_rd, mem_rf_en, mem_req, mem_ready,
        input  wb_rd, wb_rf_en,
        output pc_ifid_le, ifid_flush, idex_nop, pipe_freeze,
        output fwd_a, fwd_b, fwd_d
    );

    modport master (
        output id_ra, id_rb, id_rd_src, id_use_a, id_use_b, id_use_d,
        output ex_rd, ex_rf_en, ex_load, ex_branch_taken,
        output mem_rd, mem_rf_en, mem_req, mem_ready,
        output wb_rd, wb_rf_en,
        input  pc_ifid_le, ifid_flush, idex_nop, pipe_freeze,
        input  fwd_a, fwd_b, fwd_d
    );
endinterface

// File: rtl/hazard_controller.sv
// Hazard controller for a 5-stage pipeline (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
// Detects load-use hazards, taken-branch flushes and data-memory wait states,
// and drives the pipeline-register enables plus operand forwarding selects.
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   bus        : hazard_if.slave (stage information in, pipeline controls out)
//   stall_cnt  : saturating count of load-use and mem-wait stall cycles
//   flush_cnt  : saturating count of taken-branch flush events
module hazard_controller #(
    parameter int CNT_W       = 16,
    parameter int BOOT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    hazard_if.slave          bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES);

    state_e           state_q, state_d;
    logic [3:0]       boot_cnt_q, boot_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       pc_ifid_le, ifid_flush, idex_nop, pipe_freeze;
    logic [1:0] fwd_a, fwd_b, fwd_d;
    logic [1:0] fwd_a_sel, fwd_b_sel, fwd_d_sel;
    logic       ex_fwd_ok, load_use, mem_wait, run_rules;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) r = v;
        else    r = v + CNT_W'(1);
        return r;
    endfunction

    // Youngest producer wins: EXE, then MEM, then WB, else register file.
    function automatic logic [1:0] fwd_sel(
        input logic [3:0] src,    input logic use_src,
        input logic [3:0] ex_rd,  input logic ex_ok,
        input logic [3:0] mem_rd, input logic mem_ok,
        input logic [3:0] wb_rd,  input logic wb_ok
    );
        logic [1:0] r;
        r = 2'd0;
        if (use_src) begin
            if (ex_ok && ex_rd == src)        r = 2'd1;
            else if (mem_ok && mem_rd == src) r = 2'd2;
            else if (wb_ok && wb_rd == src)   r = 2'd3;
        end
        return r;
    endfunction

    // A load in EXE has no data yet, so it never forwards; the load-use
    // stall holds the consumer until the load reaches MEM.
    assign ex_fwd_ok = bus.ex_rf_en && !bus.ex_load;

    assign fwd_a_sel = fwd_sel(bus.id_ra, bus.id_use_a, bus.ex_rd, ex_fwd_ok,
                               bus.mem_rd, bus.mem_rf_en, bus.wb_rd, bus.wb_rf_en);
    assign fwd_b_sel = fwd_sel(bus.id_rb, bus.id_use_b, bus.ex_rd, ex_fwd_ok,
                               bus.mem_rd, bus.mem_rf_en, bus.wb_rd, bus.wb_rf_en);
    assign fwd_d_sel = fwd_sel(bus.id_rd_src, bus.id_use_d, bus.ex_rd, ex_fwd_ok,
                               bus.mem_rd, bus.mem_rf_en, bus.wb_rd, bus.wb_rf_en);

    assign load_use = bus.ex_load && bus.ex_rf_en &&
                      ((bus.id_use_a && bus.id_ra     == bus.ex_rd) ||
                       (bus.id_use_b && bus.id_rb     == bus.ex_rd) ||
                       (bus.id_use_d && bus.id_rd_src == bus.ex_rd));

    assign mem_wait = bus.mem_req && !bus.mem_ready;

    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        pc_ifid_le  = 1'b0;
        ifid_flush  = 1'b0;
        idex_nop    = 1'b0;
        pipe_freeze = 1'b0;
        fwd_a       = 2'd0;
        fwd_b       = 2'd0;
        fwd_d       = 2'd0;
        run_rules   = 1'b0;

        case (state_q)
            ST_BOOT: begin
                ifid_flush = 1'b1;
                idex_nop   = 1'b1;
                boot_cnt_d = boot_cnt_q - 4'd1;
                if (boot_cnt_q <= 4'd1) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (mem_wait) begin
                    pipe_freeze = 1'b1;
                    stall_cnt_d = sat_inc(stall_cnt_q);
                    state_d     = ST_MEM_WAIT;
                end else begin
                    run_rules = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                // The wait persists until mem_ready regardless of mem_req;
                // the completing cycle is evaluated as a normal RUN cycle.
                if (!bus.mem_ready) begin
                    pipe_freeze = 1'b1;
                    stall_cnt_d = sat_inc(stall_cnt_q);
                end else begin
                    run_rules = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // Branch outranks load-use: the flushed ID instruction is discarded,
        // so its hazard is moot and the PC loads the branch target.
        if (run_rules) begin
            if (bus.ex_branch_taken) begin
                ifid_flush  = 1'b1;
                idex_nop    = 1'b1;
                pc_ifid_le  = 1'b1;
                flush_cnt_d = sat_inc(flush_cnt_q);
            end else if (load_use) begin
                idex_nop    = 1'b1;
                stall_cnt_d = sat_inc(stall_cnt_q);
            end else begin
                pc_ifid_le  = 1'b1;
            end
        end

        if (state_q != ST_BOOT) begin
            fwd_a = fwd_a_sel;
            fwd_b = fwd_b_sel;
            fwd_d = fwd_d_sel;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_BOOT;
            boot_cnt_q  <= BOOT_INIT;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.pc_ifid_le  = pc_ifid_le;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_nop    = idex_nop;
    assign bus.pipe_freeze = pipe_freeze;
    assign bus.fwd_a       = fwd_a;
    assign bus.fwd_b       = fwd_b;
    assign bus.fwd_d       = fwd_d;
    assign stall_cnt       = stall_cnt_q;
    assign flush_cnt       = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Testbench for hazard_controller: boot sequence, table of single-cycle
// RUN-state vectors, hand-written multi-cycle sequences (load-use, mem wait,
// async reset mid-wait, counter saturation on a CNT_W=4 instance) and a
// randomized run checked against a behavioural model.
module tb_hazard_controller;

    typedef struct packed {
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rd;
        logic       ua;
        logic       ub;
        logic       ud;
        logic [3:0] ex_rd;
        logic       ex_rf;
        logic       ex_load;
        logic       br;
        logic [3:0] mem_rd;
        logic       mem_rf;
        logic       mem_req;
        logic       mem_ready;
        logic [3:0] wb_rd;
        logic       wb_rf;
    } in_t;

    typedef struct packed {
        logic       le;
        logic       fl;
        logic       nop;
        logic       frz;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [1:0] fd;
        logic       ds;
        logic       df;
        logic       wait_now;
    } exp_t;

    typedef struct {
        in_t        i;
        logic [3:0] outs;   // {le, flush, nop, freeze}
        logic [5:0] fwd;    // {fwd_a, fwd_b, fwd_d}
        int         ds;
        int         df;
    } vec_t;

    localparam int BOOT = 2;
    localparam int CMAX = 65535;

    logic        clk = 1'b0;
    logic        reset;
    logic        reset2;
    logic [15:0] stall_cnt, flush_cnt;
    logic [3:0]  stall_cnt2, flush_cnt2;

    hazard_if hif ();
    hazard_if hif2 ();

    hazard_controller #(.CNT_W(16), .BOOT_CYCLES(BOOT)) dut (
        .clk(clk), .reset(reset), .bus(hif),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_controller #(.CNT_W(4), .BOOT_CYCLES(BOOT)) dut_sat (
        .clk(clk), .reset(reset2), .bus(hif2),
        .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    in_t  cur;
    int   m_boot_left;
    bit   m_waiting;
    int   m_stall;
    int   m_flush;
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic logic [1:0] m_fwd(input logic [3:0] src, input logic use_s, input in_t x);
        logic [3:0] rd[3];
        logic       ok[3];
        logic [1:0] r;
        rd[0] = x.ex_rd;  ok[0] = x.ex_rf && !x.ex_load;
        rd[1] = x.mem_rd; ok[1] = x.mem_rf;
        rd[2] = x.wb_rd;  ok[2] = x.wb_rf;
        r = 2'd0;
        if (use_s) begin
            for (int k = 2; k >= 0; k--)
                if (ok[k] && rd[k] == src) r = 2'(k + 1);
        end
        return r;
    endfunction

    function automatic exp_t model_out(input in_t x);
        exp_t e;
        logic lu;
        e = '0;
        if (m_boot_left > 0) begin
            e.fl  = 1'b1;
            e.nop = 1'b1;
            return e;
        end
        e.fa = m_fwd(x.ra, x.ua, x);
        e.fb = m_fwd(x.rb, x.ub, x);
        e.fd = m_fwd(x.rd, x.ud, x);
        e.wait_now = m_waiting ? !x.mem_ready : (x.mem_req && !x.mem_ready);
        lu = x.ex_load && x.ex_rf &&
             ((x.ua && x.ra == x.ex_rd) || (x.ub && x.rb == x.ex_rd) || (x.ud && x.rd == x.ex_rd));
        if (e.wait_now) begin
            e.frz = 1'b1; e.ds = 1'b1;
        end else if (x.br) begin
            e.fl = 1'b1; e.nop = 1'b1; e.le = 1'b1; e.df = 1'b1;
        end else if (lu) begin
            e.nop = 1'b1; e.ds = 1'b1;
        end else begin
            e.le = 1'b1;
        end
        return e;
    endfunction

    task automatic model_reset();
        m_boot_left = BOOT;
        m_waiting   = 1'b0;
        m_stall     = 0;
        m_flush     = 0;
    endtask

    task automatic apply(input in_t x);
        cur = x;
        hif.id_ra = x.ra;   hif.id_rb = x.rb;   hif.id_rd_src = x.rd;
        hif.id_use_a = x.ua; hif.id_use_b = x.ub; hif.id_use_d = x.ud;
        hif.ex_rd = x.ex_rd; hif.ex_rf_en = x.ex_rf; hif.ex_load = x.ex_load;
        hif.ex_branch_taken = x.br;
        hif.mem_rd = x.mem_rd; hif.mem_rf_en = x.mem_rf;
        hif.mem_req = x.mem_req; hif.mem_ready = x.mem_ready;
        hif.wb_rd = x.wb_rd; hif.wb_rf_en = x.wb_rf;
    endtask

    // Compare every output against the model at the falling edge.
    task automatic eval();
        exp_t e;
        @(negedge clk);
        e = model_out(cur);
        chk("pc_ifid_le",  32'(hif.pc_ifid_le),  32'(e.le));
        chk("ifid_flush",  32'(hif.ifid_flush),  32'(e.fl));
        chk("idex_nop",    32'(hif.idex_nop),    32'(e.nop));
        chk("pipe_freeze", 32'(hif.pipe_freeze), 32'(e.frz));
        chk("fwd_a",       32'(hif.fwd_a),       32'(e.fa));
        chk("fwd_b",       32'(hif.fwd_b),       32'(e.fb));
        chk("fwd_d",       32'(hif.fwd_d),       32'(e.fd));
        chk("stall_cnt",   32'(stall_cnt),       32'(m_stall));
        chk("flush_cnt",   32'(flush_cnt),       32'(m_flush));
    endtask

    // Advance the model across one rising edge; returns 1 ns after it.
    task automatic tick();
        exp_t e;
        e = model_out(cur);
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else if (m_boot_left > 0) begin
            m_boot_left--;
        end else begin
            m_waiting = e.wait_now;
            m_stall = (m_stall + int'(e.ds) > CMAX) ? CMAX : m_stall + int'(e.ds);
            m_flush = (m_flush + int'(e.df) > CMAX) ? CMAX : m_flush + int'(e.df);
        end
        #1;
    endtask

    task automatic add_vec(input in_t x, input logic [3:0] o, input logic [5:0] f,
                           input int ds, input int df);
        vec_t v;
        v.i = x; v.outs = o; v.fwd = f; v.ds = ds; v.df = df;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        in_t idle, x;
        int  s0, f0;

        idle = '0;
        // Saturation instance: permanent load-use pattern on operand A.
        hif2.id_ra = 4'd4; hif2.id_rb = 4'd0; hif2.id_rd_src = 4'd0;
        hif2.id_use_a = 1'b1; hif2.id_use_b = 1'b0; hif2.id_use_d = 1'b0;
        hif2.ex_rd = 4'd4; hif2.ex_rf_en = 1'b1; hif2.ex_load = 1'b1;
        hif2.ex_branch_taken = 1'b0;
        hif2.mem_rd = 4'd0; hif2.mem_rf_en = 1'b0; hif2.mem_req = 1'b0;
        hif2.mem_ready = 1'b0; hif2.wb_rd = 4'd0; hif2.wb_rf_en = 1'b0;
        reset2 = 1'b0;

        // ---- reset held 3 cycles, then boot ----
        reset = 1'b0;
        model_reset();
        apply(idle);
        for (int c = 0; c < 3; c++) begin
            eval();
            chk("rst_flush", 32'(hif.ifid_flush), 32'd1);
            tick();
        end
        reset = 1'b1;
        for (int c = 0; c < BOOT; c++) begin
            eval();
            chk("boot_le",    32'(hif.pc_ifid_le), 32'd0);
            chk("boot_flush", 32'(hif.ifid_flush), 32'd1);
            chk("boot_nop",   32'(hif.idex_nop),   32'd1);
            tick();
        end
        eval();
        chk("run_le",        32'(hif.pc_ifid_le), 32'd1);
        chk("run_flush",     32'(hif.ifid_flush), 32'd0);
        chk("boot_stallcnt", 32'(stall_cnt),      32'd0);
        chk("boot_flushcnt", 32'(flush_cnt),      32'd0);
        tick();

        // ---- load-use then MEM forward ----
        x = idle; x.ex_load = 1'b1; x.ex_rf = 1'b1; x.ex_rd = 4'd4;
        x.ra = 4'd4; x.ua = 1'b1;
        apply(x);
        eval();
        chk("lu_le",  32'(hif.pc_ifid_le), 32'd0);
        chk("lu_nop", 32'(hif.idex_nop),   32'd1);
        tick();
        chk("lu_stallcnt", 32'(stall_cnt), 32'd1);
        x = idle; x.mem_rd = 4'd4; x.mem_rf = 1'b1; x.ra = 4'd4; x.ua = 1'b1;
        apply(x);
        eval();
        chk("lu_fwd_a", 32'(hif.fwd_a),      32'd2);
        chk("lu_le2",   32'(hif.pc_ifid_le), 32'd1);
        tick();

        // ---- table of single-cycle RUN vectors ----
        add_vec(idle, 4'b1000, 6'b00_00_00, 0, 0);
        x = idle; x.ex_rd = 4'd3; x.mem_rd = 4'd3; x.wb_rd = 4'd3;
        x.ex_rf = 1'b1; x.mem_rf = 1'b1; x.wb_rf = 1'b1; x.rb = 4'd3; x.ub = 1'b1;
        add_vec(x, 4'b1000, 6'b00_01_00, 0, 0);
        x.ex_rf = 1'b0;  add_vec(x, 4'b1000, 6'b00_10_00, 0, 0);
        x.mem_rf = 1'b0; add_vec(x, 4'b1000, 6'b00_11_00, 0, 0);
        x.ub = 1'b0;     add_vec(x, 4'b1000, 6'b00_00_00, 0, 0);
        x = idle; x.ex_load = 1'b1; x.ex_rf = 1'b1; x.ex_rd = 4'd5; x.rb = 4'd5; x.ub = 1'b1;
        add_vec(x, 4'b0010, 6'b00_00_00, 1, 0);
        x = idle; x.ex_load = 1'b1; x.ex_rf = 1'b1; x.ex_rd = 4'd7; x.rd = 4'd7; x.ud = 1'b1;
        add_vec(x, 4'b0010, 6'b00_00_00, 1, 0);
        x.ud = 1'b0;
        add_vec(x, 4'b1000, 6'b00_00_00, 0, 0);
        x = idle; x.br = 1'b1; x.ex_load = 1'b1; x.ex_rf = 1'b1; x.ex_rd = 4'd4;
        x.ra = 4'd4; x.ua = 1'b1;
        add_vec(x, 4'b1110, 6'b00_00_00, 0, 1);
        x = idle; x.br = 1'b1; x.mem_rd = 4'd2; x.mem_rf = 1'b1; x.ra = 4'd2; x.ua = 1'b1;
        add_vec(x, 4'b1110, 6'b10_00_00, 0, 1);
        x = idle; x.ex_rd = 4'd6; x.ex_rf = 1'b1; x.mem_rd = 4'd6; x.mem_rf = 1'b1;
        x.ra = 4'd6; x.ua = 1'b1;
        add_vec(x, 4'b1000, 6'b01_00_00, 0, 0);
        x = idle; x.mem_req = 1'b1; x.mem_ready = 1'b1;
        add_vec(x, 4'b1000, 6'b00_00_00, 0, 0);
        x = idle; x.ra = 4'd1; x.ua = 1'b1; x.ex_rd = 4'd1; x.ex_rf = 1'b1;
        x.rb = 4'd2; x.ub = 1'b1; x.mem_rd = 4'd2; x.mem_rf = 1'b1;
        x.rd = 4'd3; x.ud = 1'b1; x.wb_rd = 4'd3; x.wb_rf = 1'b1;
        add_vec(x, 4'b1000, 6'b01_10_11, 0, 0);

        foreach (vecs[n]) begin
            apply(vecs[n].i);
            s0 = int'(stall_cnt);
            f0 = int'(flush_cnt);
            eval();
            chk($sformatf("vec%0d_ctl", n),
                32'({hif.pc_ifid_le, hif.ifid_flush, hif.idex_nop, hif.pipe_freeze}),
                32'(vecs[n].outs));
            chk($sformatf("vec%0d_fwd", n), 32'({hif.fwd_a, hif.fwd_b, hif.fwd_d}),
                32'(vecs[n].fwd));
            tick();
            chk($sformatf("vec%0d_dstall", n), 32'(int'(stall_cnt) - s0), 32'(vecs[n].ds));
            chk($sformatf("vec%0d_dflush", n), 32'(int'(flush_cnt) - f0), 32'(vecs[n].df));
        end

        // ---- memory wait: 3 wait cycles then ready ----
        s0 = int'(stall_cnt);
        x = idle; x.mem_req = 1'b1; x.mem_ready = 1'b0;
        apply(x);
        for (int c = 0; c < 3; c++) begin
            eval();
            chk("mw_freeze", 32'(hif.pipe_freeze), 32'd1);
            chk("mw_le",     32'(hif.pc_ifid_le),  32'd0);
            tick();
        end
        x.mem_ready = 1'b1;
        apply(x);
        eval();
        chk("mw_ready_freeze", 32'(hif.pipe_freeze), 32'd0);
        chk("mw_ready_le",     32'(hif.pc_ifid_le),  32'd1);
        tick();
        chk("mw_stall_delta", 32'(int'(stall_cnt) - s0), 32'd3);
        apply(idle);
        eval();
        chk("mw_back_run", 32'(hif.pc_ifid_le), 32'd1);
        tick();

        // ---- async reset in the middle of a memory wait ----
        x = idle; x.mem_req = 1'b1; x.mem_ready = 1'b0;
        apply(x);
        eval();
        tick();
        eval();
        #1 reset = 1'b0;
        #1;
        chk("arst_le",     32'(hif.pc_ifid_le),  32'd0);
        chk("arst_flush",  32'(hif.ifid_flush),  32'd1);
        chk("arst_nop",    32'(hif.idex_nop),    32'd1);
        chk("arst_freeze", 32'(hif.pipe_freeze), 32'd0);
        chk("arst_stall",  32'(stall_cnt),       32'd0);
        model_reset();
        apply(idle);
        tick();
        reset = 1'b1;

        // ---- randomized run against the model ----
        for (int n = 0; n < 400; n++) begin
            x.ra = 4'($urandom_range(0, 3));  x.rb = 4'($urandom_range(0, 3));
            x.rd = 4'($urandom_range(0, 3));
            x.ua = 1'($urandom_range(0, 1));  x.ub = 1'($urandom_range(0, 1));
            x.ud = 1'($urandom_range(0, 1));
            x.ex_rd = 4'($urandom_range(0, 3)); x.ex_rf = 1'($urandom_range(0, 1));
            x.ex_load = 1'($urandom_range(0, 1));
            x.br = ($urandom_range(0, 4) == 0);
            x.mem_rd = 4'($urandom_range(0, 3)); x.mem_rf = 1'($urandom_range(0, 1));
            x.mem_req = ($urandom_range(0, 2) == 0);
            x.mem_ready = 1'($urandom_range(0, 1));
            x.wb_rd = 4'($urandom_range(0, 3)); x.wb_rf = 1'($urandom_range(0, 1));
            apply(x);
            eval();
            tick();
        end

        // ---- saturation on the CNT_W=4 instance: 20 load-use stalls ----
        apply(idle);
        reset2 = 1'b1;
        for (int c = 0; c < BOOT; c++) tick();
        chk("sat_start", 32'(stall_cnt2), 32'd0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("sat_stall%0d", k), 32'(stall_cnt2), 32'((k > 15) ? 15 : k));
        end
        chk("sat_flush", 32'(flush_cnt2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
